uart_r: RTL and testbench
=========================

Name: uart_r

Overview:
- Serial receiver matching the existing UART transmitter framing: start bit 0, D_WIDTH data bits LSB first, stop bit 1, line idles at 1.
- Recovers each frame from the serial line and presents the data word on a parallel port.
- The word is held valid until acknowledged. Overrun and framing errors are flagged.
- Sits at the receive end of a link driven by the team's transmitter; default rate is one bit per clock, matching it.

Parameters:
- D_WIDTH, 13, data bits per frame.
- CLKS_PER_BIT, 1, clock cycles per serial bit (≥1). HALF = (CLKS_PER_BIT-1)/2, integer division.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, asynchronous to clk.
- rx_ack  input  1  consumer acknowledge; clears rx_valid and rx_overrun.
- rx_data  output  D_WIDTH  last correctly framed word.
- rx_valid  output  1  rx_data holds an unacknowledged word.
- rx_busy  output  1  frame reception in progress (state not IDLE).
- rx_ferr  output  1  one-cycle pulse: stop bit sampled 0.
- rx_overrun  output  1  sticky: a word was overwritten before acknowledge.

Behaviour:
- Reset (rst=0, asynchronous):
  - rx_data=0, rx_valid=0, rx_busy=0, rx_ferr=0, rx_overrun=0.
  - State=IDLE; all counters 0.
  - Both synchronizer flops = 1.
  - Reset asserted mid-frame discards the partial frame; no flags are raised.
- Synchronizer: rx passes through two flops; rx_s is rx delayed 2 cycles. All decisions use rx_s.
- Timing reference: the start edge is the first cycle in IDLE with rx_s=0, sample offset 0. All offsets below count cycles from that edge.
  - Start check at offset HALF.
  - Data bit i (i=0..D_WIDTH-1) sampled at offset HALF+(i+1)*CLKS_PER_BIT, into rx_data bit i.
  - Stop bit sampled at offset HALF+(D_WIDTH+1)*CLKS_PER_BIT.
- State machine:
  - IDLE:
    - rx_s=0 → START. When HALF=0, the edge sample is itself the start check, and the FSM goes directly to DATA.
  - START:
    - At the start check, rx_s=1 → false start, return to IDLE with no flags.
    - At the start check, rx_s=0 → DATA.
  - DATA:
    - Shift in D_WIDTH samples into an internal shift register.
    - After the last data sample → STOP.
  - STOP, at the stop sample:
    - rx_s=1: next cycle rx_data ← shift register and rx_valid=1; state → IDLE. A new start edge is accepted on the very next IDLE cycle.
    - rx_s=0: rx_ferr pulses for 1 cycle; rx_data and rx_valid unchanged; → WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then → IDLE. This prevents a break condition from being read as a start edge.
- rx_busy = 1 in START, DATA, STOP and WAIT_IDLE.
- Latency: rx_valid rises 2+HALF+(D_WIDTH+1)*CLKS_PER_BIT+1 cycles after the first cycle in which the rx pin is low. With defaults this is 17 cycles.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid and rx_overrun on the next cycle.
  - rx_ack with rx_valid=0 is ignored.
- Overrun: a word completes while rx_valid=1 and rx_ack=0 → rx_data is overwritten, rx_valid stays 1, rx_overrun ← 1 (sticky).
- Simultaneous completion and rx_ack: the new word wins. rx_valid stays 1 with the new data; rx_overrun ← 0.
- Counter widths:
  - Bit counter: clog2(D_WIDTH+1) bits.
  - Sample counter: clog2(CLKS_PER_BIT+1) bits.
  - Counters never wrap within a frame; they are reloaded on every state entry.
- rx glitches in IDLE that are shorter than HALF+1 cycles are rejected by the start check. This applies only when CLKS_PER_BIT≥3.

Test Plan:
1. Defaults; send frame with data 13'h1A5B (start 0, LSB first, stop 1) → rx_valid rises exactly 17 cycles after rx falls; rx_data=13'h1A5B; rx_ferr=0.
2. Two back-to-back frames 13'h0001 then 13'h1FFF; no rx_ack → rx_data=13'h1FFF, rx_valid=1, rx_overrun=1. Then rx_ack for one cycle → rx_valid=0 and rx_overrun=0 next cycle.
3. Frame 13'h0AAA with stop bit forced 0, line held 0 for 5 more cycles, then frame 13'h0555 → rx_ferr single pulse, rx_data stays at prior value; state is in WAIT_IDLE while the line is low; then rx_data=13'h0555, rx_valid=1.
4. CLKS_PER_BIT=4; 1-cycle low glitch on rx, then valid frame 13'h1234 at 4 cycles/bit → glitch ignored (rx_busy pulses, no flags); rx_data=13'h1234 after 2+1+14*4+1=60 cycles.
5. Assert rst=0 mid-way through DATA of frame 13'h0F0F, release, then send 13'h0123 → all outputs 0 immediately (asynchronously); no rx_ferr; next frame received as 13'h0123.
6. rx_ack asserted in the same cycle a new word completes while rx_valid=1 → rx_valid stays 1, rx_data=new word, rx_overrun=0.

Source files
------------

// File: rtl/uart_r.sv
// uart_r -- serial receiver for the link driven by the matching UART
// transmitter. Frame format: one start bit (0), D_WIDTH data bits sent LSB
// first, one stop bit (1). The line idles at 1.
//
// The received word is held on rx_data with rx_valid set until the consumer
// acknowledges it. Framing errors and overruns are reported.
//
// Parameters:
//   D_WIDTH       data bits per frame
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous, active-low reset
//   rx          serial line, asynchronous to clk
//   rx_ack      consumer acknowledge; clears rx_valid and rx_overrun
//   rx_data     last correctly framed word
//   rx_valid    rx_data holds an unacknowledged word
//   rx_busy     a frame is being received (state not IDLE)
//   rx_ferr     one-cycle pulse: stop bit sampled as 0
//   rx_overrun  sticky: a word was overwritten before it was acknowledged
module uart_r #(
    parameter int unsigned D_WIDTH      = 13,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    input  logic               rx_ack,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_busy,
    output logic               rx_ferr,
    output logic               rx_overrun
);

    // Start-check offset from the detected falling edge.
    localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;

    localparam int unsigned BW = $clog2(D_WIDTH + 1);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(D_WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    // START is only entered when HALF > 0, so the HALF == 0 value is unused.
    localparam logic [CW-1:0] HALF_LAST = CW'((HALF > 0) ? (HALF - 1) : 0);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    logic               sync1_q,   sync1_d;
    logic               sync2_q,   sync2_d;
    logic [2:0]         state_q,   state_d;
    logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]      smp_cnt_q, smp_cnt_d;
    logic [D_WIDTH-1:0] shreg_q,   shreg_d;
    logic [D_WIDTH-1:0] data_q,    data_d;
    logic               valid_q,   valid_d;
    logic               ferr_q,    ferr_d;
    logic               ovr_q,     ovr_d;

    logic               rx_s;
    logic               word_done;

    assign rx_s = sync2_q;

    always_comb begin
        sync1_d   = rx;
        sync2_d   = sync1_q;
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        smp_cnt_d = smp_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = ovr_q;
        word_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    smp_cnt_d = '0;
                    bit_cnt_d = '0;
                    // With HALF == 0 the edge sample itself is the start check.
                    state_d   = (HALF == 0) ? ST_DATA : ST_START;
                end
            end

            ST_START: begin
                if (smp_cnt_q == HALF_LAST) begin
                    smp_cnt_d = '0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    smp_cnt_d = smp_cnt_q + CW'(1);
                end
            end

            ST_DATA: begin
                if (smp_cnt_q == CNT_LAST) begin
                    smp_cnt_d = '0;
                    // LSB arrives first: shift right so it ends up in bit 0.
                    shreg_d   = {rx_s, shreg_q[D_WIDTH-1:1]};
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end else begin
                    smp_cnt_d = smp_cnt_q + CW'(1);
                end
            end

            ST_STOP: begin
                if (smp_cnt_q == CNT_LAST) begin
                    smp_cnt_d = '0;
                    if (rx_s) begin
                        word_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    smp_cnt_d = smp_cnt_q + CW'(1);
                end
            end

            ST_WAIT_IDLE: begin
                // Hold off until the line returns high so a break is not
                // mistaken for a new start edge.
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A completing word takes priority over an acknowledge in the same
        // cycle: the new word stays valid and the overrun flag is cleared.
        if (word_done) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            if (valid_q && !rx_ack) begin
                ovr_d = 1'b1;
            end else if (valid_q && rx_ack) begin
                ovr_d = 1'b0;
            end
        end else if (valid_q && rx_ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            smp_cnt_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign rx_busy    = (state_q != ST_IDLE);
    assign rx_ferr    = ferr_q;
    assign rx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_r.sv
// tb_uart_r -- directed bench for uart_r. Two instances share clock and
// reset: one at one clock per bit, one at four clocks per bit. Words are
// queued when their frame is driven and popped when the receiver presents
// them.
module tb_uart_r;

    logic        clk;
    logic        rst;
    logic        rx1, rx4;
    logic        ack1, ack4;
    logic [12:0] data1, data4;
    logic        valid1, valid4;
    logic        busy1, busy4;
    logic        ferr1, ferr4;
    logic        ovr1, ovr4;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int ferr1_cnt = 0;
    int ferr4_cnt = 0;

    logic [12:0] exp_q[$];

    uart_r #(.D_WIDTH(13), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .rx_ack(ack1),
        .rx_data(data1), .rx_valid(valid1), .rx_busy(busy1),
        .rx_ferr(ferr1), .rx_overrun(ovr1)
    );

    uart_r #(.D_WIDTH(13), .CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .rx(rx4), .rx_ack(ack4),
        .rx_data(data4), .rx_valid(valid4), .rx_busy(busy4),
        .rx_ferr(ferr4), .rx_overrun(ovr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ferr1 === 1'b1) ferr1_cnt++;
        if (ferr4 === 1'b1) ferr4_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic chk_pop(input string tag, input logic [12:0] obs);
        logic [12:0] e;
        if (exp_q.size() == 0) begin
            n_total++;
            $error("FAIL %s: observed 0x%0h expected <scoreboard empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(obs), 32'(e));
        end
    endtask

    task automatic set_rx(input bit sel4, input logic b);
        if (sel4) rx4 = b;
        else      rx1 = b;
    endtask

    // Call aligned 1 time unit after a rising edge; returns aligned the same
    // way, with the line left at the stop-bit value.
    task automatic drive_frame(input logic [12:0] d, input logic stop_v, input int cpb,
                               input bit sel4, input bit push, output int k0);
        k0 = cyc;
        if (push) exp_q.push_back(d);
        set_rx(sel4, 1'b0);
        repeat (cpb) @(posedge clk);
        #1;
        for (int i = 0; i < 13; i++) begin
            set_rx(sel4, d[i]);
            repeat (cpb) @(posedge clk);
            #1;
        end
        set_rx(sel4, stop_v);
        repeat (cpb) @(posedge clk);
        #1;
    endtask

    // Returns at the falling edge where rx_valid is first seen high, or -1.
    task automatic wait_valid(input bit sel4, output int at);
        at = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((sel4 ? valid4 : valid1) === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic align;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k0, k1, at, f0, g;

        rst  = 1'b0;
        rx1  = 1'b1;
        rx4  = 1'b1;
        ack1 = 1'b0;
        ack4 = 1'b0;

        // Reset state.
        #3;
        chk("rst data1",  32'(data1), 32'h0);
        chk("rst valid1", 32'(valid1), 32'h0);
        chk("rst busy1",  32'(busy1), 32'h0);
        chk("rst ferr1",  32'(ferr1), 32'h0);
        chk("rst ovr1",   32'(ovr1), 32'h0);
        chk("rst valid4", 32'(valid4), 32'h0);
        repeat (3) align();
        rst = 1'b1;
        repeat (3) align();

        // 1: single frame, 17-cycle latency.
        drive_frame(13'h1A5B, 1'b1, 1, 1'b0, 1'b1, k0);
        wait_valid(1'b0, at);
        chk("t1 latency", 32'(at - k0), 32'd17);
        chk_pop("t1 data", data1);
        chk("t1 ferr", 32'(ferr1_cnt), 32'd0);
        chk("t1 ovr", 32'(ovr1), 32'h0);
        align();
        ack1 = 1'b1;
        align();
        ack1 = 1'b0;
        @(negedge clk);
        chk("t1 ack valid", 32'(valid1), 32'h0);
        align();

        // 2: back-to-back frames without acknowledge.
        drive_frame(13'h0001, 1'b1, 1, 1'b0, 1'b1, k0);
        drive_frame(13'h1FFF, 1'b1, 1, 1'b0, 1'b1, k1);
        repeat (3) @(negedge clk);
        chk("t2 valid", 32'(valid1), 32'h1);
        chk("t2 ovr", 32'(ovr1), 32'h1);
        void'(exp_q.pop_front());   // first word was overwritten
        chk_pop("t2 data", data1);
        align();
        ack1 = 1'b1;
        align();
        ack1 = 1'b0;
        @(negedge clk);
        chk("t2 ack valid", 32'(valid1), 32'h0);
        chk("t2 ack ovr", 32'(ovr1), 32'h0);
        align();

        // 3: framing error, break held, then a good frame.
        f0 = ferr1_cnt;
        drive_frame(13'h0AAA, 1'b0, 1, 1'b0, 1'b0, k0);
        repeat (5) align();
        @(negedge clk);
        chk("t3 busy in wait", 32'(busy1), 32'h1);
        chk("t3 ferr pulses", 32'(ferr1_cnt - f0), 32'd1);
        chk("t3 data kept", 32'(data1), 32'h1FFF);
        chk("t3 valid", 32'(valid1), 32'h0);
        align();
        rx1 = 1'b1;
        repeat (3) align();
        drive_frame(13'h0555, 1'b1, 1, 1'b0, 1'b1, k0);
        wait_valid(1'b0, at);
        chk("t3 latency", 32'(at - k0), 32'd17);
        chk_pop("t3 data", data1);
        chk("t3 no new ferr", 32'(ferr1_cnt - f0), 32'd1);
        align();

        // 4: glitch rejection and a frame at 4 clocks per bit.
        g = cyc;
        rx4 = 1'b0;
        align();
        rx4 = 1'b1;
        @(negedge clk);
        while (cyc < g + 3) @(negedge clk);
        chk("t4 glitch busy", 32'(busy4), 32'h1);
        @(negedge clk);
        chk("t4 glitch idle", 32'(busy4), 32'h0);
        align();
        repeat (4) align();
        chk("t4 glitch valid", 32'(valid4), 32'h0);
        chk("t4 glitch ferr", 32'(ferr4_cnt), 32'd0);
        drive_frame(13'h1234, 1'b1, 4, 1'b1, 1'b1, k0);
        wait_valid(1'b1, at);
        chk("t4 latency", 32'(at - k0), 32'd60);
        chk_pop("t4 data", data4);
        chk("t4 ovr", 32'(ovr4), 32'h0);
        align();

        // 5: asynchronous reset in the middle of a frame.
        f0 = ferr1_cnt;
        rx1 = 1'b0;
        align();
        for (int i = 0; i < 6; i++) begin
            rx1 = (i % 8) < 4;   // low bits of 13'h0F0F
            align();
        end
        #2;
        rst = 1'b0;
        #1;
        chk("t5 rst data", 32'(data1), 32'h0);
        chk("t5 rst valid", 32'(valid1), 32'h0);
        chk("t5 rst busy", 32'(busy1), 32'h0);
        chk("t5 rst ovr", 32'(ovr1), 32'h0);
        rx1 = 1'b1;
        align();
        rst = 1'b1;
        repeat (3) align();
        drive_frame(13'h0123, 1'b1, 1, 1'b0, 1'b1, k0);
        wait_valid(1'b0, at);
        chk("t5 latency", 32'(at - k0), 32'd17);
        chk_pop("t5 data", data1);
        chk("t5 no ferr", 32'(ferr1_cnt - f0), 32'd0);
        align();

        // 6: acknowledge in the completion cycle of a new word.
        drive_frame(13'h1111, 1'b1, 1, 1'b0, 1'b1, k0);
        repeat (3) @(negedge clk);
        chk("t6 pre ovr", 32'(ovr1), 32'h1);
        chk_pop("t6 pre data", data1);
        align();
        drive_frame(13'h0ABC, 1'b1, 1, 1'b0, 1'b1, k1);
        align();
        ack1 = 1'b1;
        align();
        ack1 = 1'b0;
        @(negedge clk);
        chk("t6 valid", 32'(valid1), 32'h1);
        chk("t6 ovr", 32'(ovr1), 32'h0);
        chk_pop("t6 data", data1);
        @(negedge clk);
        chk("t6 valid held", 32'(valid1), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
